// File: rtl/seg_scan_ctrl.sv
// Eight-digit 7-segment scan controller with blanking between digits.
// Optional leading-zero suppression when SEG_SCAN_ZERO_BLANK_EN is defined.
module seg_scan_ctrl #(
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_idx,
  input  logic [3:0] wr_data,
  input  logic [7:0] digit_mask,
  output logic [2:0] sel,
  output logic       sel_en,
  output logic [7:0] seg_n,
  output logic       frame_done
);

  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic            lit_q, lit_d;
  logic            fd_q, fd_d;
  logic            sel_en_q, sel_en_d;
  logic [7:0]      seg_n_q, seg_n_d;
  logic [7:0][3:0] digit_q, digit_d;
  logic [7:0]      zero_ok;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  // Only the digit currently lit is write-protected; every other index accepts at once.
  assign wr_ready = !(state_q == SHOW && wr_idx == sel_q);

  always_comb begin
    digit_d = digit_q;
    if (wr_valid && wr_ready) digit_d[wr_idx] = wr_data;
  end

`ifdef SEG_SCAN_ZERO_BLANK_EN
  // Digit i is suppressed when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    zero_ok = '1;
    for (int i = 7; i >= 1; i--) begin
      hi_zero    = hi_zero && (digit_d[i] == 4'h0);
      zero_ok[i] = !hi_zero;
    end
  end
`else
  assign zero_ok = '1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    sel_d   = sel_q;
    lit_d   = lit_q;
    fd_d    = 1'b0;
    case (state_q)
      BLANK: if (cnt_q == CW'(BLANK_CYC - 1)) begin
        state_d = SHOW;
        cnt_d   = '0;
        lit_d   = digit_mask[sel_q] && zero_ok[sel_q];
      end
      SHOW: if (cnt_q == CW'(DIV - 1)) begin
        state_d = BLANK;
        cnt_d   = '0;
        sel_d   = sel_q + 3'd1;
        fd_d    = (sel_q == 3'd7);
      end
      default: state_d = BLANK;
    endcase
    // Outputs are computed from next-state values so they align with the state register;
    // digit_d lets a write on the last BLANK cycle appear in the SHOW that follows.
    sel_en_d = (state_d == SHOW) && lit_d;
    seg_n_d  = sel_en_d ? hex7(digit_d[sel_d]) : 8'hFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BLANK;
      cnt_q    <= '0;
      sel_q    <= '0;
      lit_q    <= 1'b0;
      fd_q     <= 1'b0;
      sel_en_q <= 1'b0;
      seg_n_q  <= 8'hFF;
      digit_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      lit_q    <= lit_d;
      fd_q     <= fd_d;
      sel_en_q <= sel_en_d;
      seg_n_q  <= seg_n_d;
      digit_q  <= digit_d;
    end
  end

  assign sel        = sel_q;
  assign sel_en     = sel_en_q;
  assign seg_n      = seg_n_q;
  assign frame_done = fd_q;

endmodule
